// File: rtl/regfile_pkg.sv
// Shared constants for the register file with pending-write scoreboard.
//   XLEN_DEF / NREGS_DEF : default data width and register count
//   ZERO_REG             : index of the hardwired-zero register (x0)
//   addr_width()         : register address width derived from the register count
package regfile_pkg;

    localparam int unsigned XLEN_DEF  = 64;
    localparam int unsigned NREGS_DEF = 32;
    localparam int unsigned ZERO_REG  = 0;

    // Register count is a power of two >= 2, so this is log2(nregs); the guard keeps
    // the result at least 1 bit wide.
    function automatic int unsigned addr_width(input int unsigned nregs);
        return (nregs < 2) ? 1 : $clog2(nregs);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register plus a busy count.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   ra_i, rb_i           : read addresses, give busy_a_o / busy_b_o
//   issue_i, rd_i        : reserve rd_i for a new producer; issue_ok_o says it is allowed
//   we_i, rw_i           : writeback releases rw_i
//   flush_i              : clears every busy bit and the count
//   busy_count_o         : number of busy registers
// BypassEn hides the busy bit of a register being written back in the same cycle.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS    = NREGS_DEF,
    parameter bit          BypassEn = 1'b0,
    localparam int unsigned AW      = addr_width(NREGS)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [AW-1:0] ra_i,
    input  logic [AW-1:0] rb_i,
    input  logic          issue_i,
    input  logic [AW-1:0] rd_i,
    input  logic          we_i,
    input  logic [AW-1:0] rw_i,
    input  logic          flush_i,
    output logic          busy_a_o,
    output logic          busy_b_o,
    output logic          issue_ok_o,
    output logic [AW-1:0] busy_count_o
);

    localparam logic [AW-1:0] Zero = AW'(ZERO_REG);

    logic [NREGS-1:0] busy_q, busy_d;
    logic [AW-1:0]    count_q, count_d;
    logic             issue_ok;
    logic             set_en, clr_en, inc, dec;

    always_comb begin
        // A writeback to rd this cycle releases the old producer, so re-reserving is fine.
        issue_ok = !busy_q[rd_i] || (we_i && (rw_i == rd_i)) || (rd_i == Zero);
        set_en   = issue_i && issue_ok && (rd_i != Zero) && !flush_i;
        clr_en   = we_i && (rw_i != Zero);
        // Count only real 0->1 and 1->0 transitions; a same-register clear+set is a no-op.
        inc      = set_en && !busy_q[rd_i];
        dec      = clr_en && busy_q[rw_i] && !(set_en && (rw_i == rd_i));

        busy_d  = busy_q;
        count_d = count_q + AW'(inc) - AW'(dec);
        if (clr_en) busy_d[rw_i] = 1'b0;
        if (set_en) busy_d[rd_i] = 1'b1;
        if (flush_i) begin
            busy_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        busy_a_o     = busy_q[ra_i] && !(BypassEn && we_i && (rw_i == ra_i));
        busy_b_o     = busy_q[rb_i] && !(BypassEn && we_i && (rw_i == rb_i));
        issue_ok_o   = issue_ok;
        busy_count_o = count_q;
    end

    issue_legal_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
        issue_i |-> issue_ok)
        else $error("ISSUE asserted while IssueOk is low");

endmodule

// File: rtl/regfile_sb.sv
// Register file with pending-write scoreboard for the pipelined RISC-V datapath.
// Two combinational read ports, one synchronous write port, x0 hardwired to zero.
//   CLK, RST_N        : clock, asynchronous active-low reset
//   Ra/Rb -> Da/Db    : combinational reads, BusyA/BusyB flag pending writes
//   ISSUE, Rd         : reserve Rd for an in-flight producer; IssueOk flags no WAW hazard
//   WE, Rw, Din       : writeback, writes data and releases Rw
//   FLUSH             : clear all busy bits
//   BusyCount         : number of busy registers
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned NREGS = NREGS_DEF,
    localparam int unsigned AW   = addr_width(NREGS)
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [AW-1:0]   Ra,
    input  logic [AW-1:0]   Rb,
    output logic [XLEN-1:0] Da,
    output logic [XLEN-1:0] Db,
    output logic            BusyA,
    output logic            BusyB,
    input  logic            ISSUE,
    input  logic [AW-1:0]   Rd,
    output logic            IssueOk,
    input  logic            WE,
    input  logic [AW-1:0]   Rw,
    input  logic [XLEN-1:0] Din,
    input  logic            FLUSH,
    output logic [AW-1:0]   BusyCount
);

`ifdef REGFILE_BYPASS_EN
    localparam bit BypassEn = 1'b1;
`else
    localparam bit BypassEn = 1'b0;
`endif

    localparam logic [AW-1:0] Zero = AW'(ZERO_REG);

    logic [XLEN-1:0] mem_q [NREGS];
    logic            wr_en;
    logic            byp_a, byp_b;

    assign wr_en = WE && (Rw != Zero);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[Rw] <= Din;
        end
    end

    always_comb begin
        // Reset gates the bypass so reads are zero while reset is held.
        byp_a = BypassEn && RST_N && wr_en && (Rw == Ra);
        byp_b = BypassEn && RST_N && wr_en && (Rw == Rb);
        Da    = (Ra == Zero) ? '0 : (byp_a ? Din : mem_q[Ra]);
        Db    = (Rb == Zero) ? '0 : (byp_b ? Din : mem_q[Rb]);
    end

    regfile_scoreboard #(
        .NREGS    (NREGS),
        .BypassEn (BypassEn)
    ) u_scoreboard (
        .clk_i        (CLK),
        .rst_ni       (RST_N),
        .ra_i         (Ra),
        .rb_i         (Rb),
        .issue_i      (ISSUE),
        .rd_i         (Rd),
        .we_i         (WE),
        .rw_i         (Rw),
        .flush_i      (FLUSH),
        .busy_a_o     (BusyA),
        .busy_b_o     (BusyB),
        .issue_ok_o   (IssueOk),
        .busy_count_o (BusyCount)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed vector table, random traffic against a reference
// model, and a mid-run asynchronous reset sequence.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [4:0]  Ra, Rb, Rd, Rw;
    logic [63:0] Da, Db, Din;
    logic        BusyA, BusyB, ISSUE, IssueOk, WE, FLUSH;
    logic [4:0]  BusyCount;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    regfile_sb dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .Ra        (Ra),
        .Rb        (Rb),
        .Da        (Da),
        .Db        (Db),
        .BusyA     (BusyA),
        .BusyB     (BusyB),
        .ISSUE     (ISSUE),
        .Rd        (Rd),
        .IssueOk   (IssueOk),
        .WE        (WE),
        .Rw        (Rw),
        .Din       (Din),
        .FLUSH     (FLUSH),
        .BusyCount (BusyCount)
    );

    typedef struct {
        logic [4:0]  ra, rb, rd, rw;
        logic        issue, we, flush;
        logic [63:0] din;
    } stim_t;

    typedef struct {
        logic [63:0] da, db;
        logic        ba, bb, ok;
        logic [4:0]  cnt;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    // Reference model: plain array of values and a set of busy registers.
    logic [63:0] m_reg [32];
    bit          m_busy [32];

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endfunction

    function automatic logic [63:0] model_read(input logic [4:0] a, input stim_t s);
        if (a == 0) return '0;
        if (BYP && s.we && s.rw == a) return s.din;
        return m_reg[a];
    endfunction

    function automatic exp_t model_out(input stim_t s);
        exp_t e;
        int   n = 0;
        e.da = model_read(s.ra, s);
        e.db = model_read(s.rb, s);
        e.ba = m_busy[s.ra] && !(BYP && s.we && s.rw == s.ra);
        e.bb = m_busy[s.rb] && !(BYP && s.we && s.rw == s.rb);
        e.ok = !m_busy[s.rd] || (s.we && s.rw == s.rd) || (s.rd == 0);
        for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
        e.cnt = 5'(n);
        return e;
    endfunction

    function automatic void model_edge(input stim_t s);
        bit ok;
        ok = !m_busy[s.rd] || (s.we && s.rw == s.rd) || (s.rd == 0);
        if (s.we && s.rw != 0) begin
            m_reg[s.rw]  = s.din;
            m_busy[s.rw] = 1'b0;
        end
        if (s.flush) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        end else if (s.issue && ok && s.rd != 0) begin
            m_busy[s.rd] = 1'b1;
        end
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input exp_t e);
        chk({tag, ".Da"}, Da, e.da);
        chk({tag, ".Db"}, Db, e.db);
        chk({tag, ".BusyA"}, 64'(BusyA), 64'(e.ba));
        chk({tag, ".BusyB"}, 64'(BusyB), 64'(e.bb));
        chk({tag, ".IssueOk"}, 64'(IssueOk), 64'(e.ok));
        chk({tag, ".BusyCount"}, 64'(BusyCount), 64'(e.cnt));
    endtask

    task automatic drive(input stim_t s);
        Ra = s.ra; Rb = s.rb; Rd = s.rd; Rw = s.rw;
        ISSUE = s.issue; WE = s.we; FLUSH = s.flush; Din = s.din;
    endtask

    // Called just after a rising edge: drive, check at the falling edge, clock, update model.
    task automatic step(input stim_t s, input bit use_tbl, input exp_t te, input string tag);
        drive(s);
        @(negedge CLK);
        chk_out({tag, "/model"}, model_out(s));
        if (use_tbl) chk_out({tag, "/table"}, te);
        @(posedge CLK);
        model_edge(s);
        #1;
    endtask

    function automatic vec_t v(input int ra, input int rb, input int issue, input int rd,
                               input int we, input int rw, input longint din, input int flush,
                               input longint da, input longint db, input int ba, input int bb,
                               input int ok, input int cnt);
        vec_t r;
        r.s.ra = 5'(ra); r.s.rb = 5'(rb); r.s.issue = issue[0]; r.s.rd = 5'(rd);
        r.s.we = we[0]; r.s.rw = 5'(rw); r.s.din = 64'(din); r.s.flush = flush[0];
        r.e.da = 64'(da); r.e.db = 64'(db); r.e.ba = ba[0]; r.e.bb = bb[0];
        r.e.ok = ok[0]; r.e.cnt = 5'(cnt);
        return r;
    endfunction

    function automatic logic [4:0] rand_addr();
        return ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.ra = rand_addr(); s.rb = rand_addr(); s.rd = rand_addr(); s.rw = rand_addr();
        s.we    = ($urandom_range(0, 1) == 1);
        s.din   = {$urandom, $urandom};
        s.flush = ($urandom_range(0, 15) == 0);
        s.issue = 1'b0;
        // Never issue against a WAW hazard: that is illegal stimulus.
        if ($urandom_range(0, 1) == 1) s.issue = model_out(s).ok;
        return s;
    endfunction

    vec_t  tbl[$];
    exp_t  none;
    stim_t q;

    initial begin
        none = '{da: '0, db: '0, ba: 1'b0, bb: 1'b0, ok: 1'b0, cnt: '0};
        q    = '{ra: 5'd1, rb: 5'd2, rd: 5'd3, rw: 5'd0, issue: 1'b0, we: 1'b0, flush: 1'b0,
                 din: '0};

        // ra, rb, issue, rd, we, rw, din, flush | da, db, ba, bb, ok, cnt (before the edge)
        tbl.push_back(v(0, 0,  0, 0,  1, 1,  234, 0,  0, 0, 0, 0, 1, 0));
        tbl.push_back(v(0, 1,  0, 0,  0, 0,  0,   0,  0, 234, 0, 0, 1, 0));
        tbl.push_back(v(0, 1,  0, 0,  1, 0,  672, 0,  0, 234, 0, 0, 1, 0));
        tbl.push_back(v(0, 1,  0, 0,  0, 0,  0,   0,  0, 234, 0, 0, 1, 0));
        tbl.push_back(v(0, 18, 1, 18, 0, 0,  0,   0,  0, 0, 0, 0, 1, 0));
        tbl.push_back(v(0, 18, 0, 18, 0, 0,  0,   0,  0, 0, 0, 1, 0, 1));
        tbl.push_back(v(0, 18, 0, 18, 1, 18, 672, 0,  0, BYP ? 672 : 0, 0, BYP ? 0 : 1, 1, 1));
        tbl.push_back(v(0, 18, 0, 18, 0, 0,  0,   0,  0, 672, 0, 0, 1, 0));
        tbl.push_back(v(5, 0,  1, 5,  0, 0,  0,   0,  0, 0, 0, 0, 1, 0));
        tbl.push_back(v(5, 0,  1, 5,  1, 5,  7,   0,  BYP ? 7 : 0, 0, BYP ? 0 : 1, 0, 1, 1));
        tbl.push_back(v(5, 0,  0, 5,  0, 0,  0,   0,  7, 0, 1, 0, 0, 1));
        tbl.push_back(v(5, 0,  0, 5,  1, 5,  7,   0,  7, 0, BYP ? 0 : 1, 0, 1, 1));
        tbl.push_back(v(5, 0,  1, 3,  0, 0,  0,   0,  7, 0, 0, 0, 1, 0));
        tbl.push_back(v(5, 0,  1, 4,  0, 0,  0,   0,  7, 0, 0, 0, 1, 1));
        tbl.push_back(v(5, 0,  1, 9,  0, 0,  0,   0,  7, 0, 0, 0, 1, 2));
        tbl.push_back(v(9, 10, 1, 10, 0, 0,  0,   1,  0, 0, 1, 0, 1, 3));
        tbl.push_back(v(9, 10, 0, 10, 0, 0,  0,   0,  0, 0, 0, 0, 1, 0));
        tbl.push_back(v(7, 0,  0, 0,  1, 7,  99,  0,  BYP ? 99 : 0, 0, 0, 0, 1, 0));
        tbl.push_back(v(7, 0,  0, 0,  0, 0,  0,   0,  99, 0, 0, 0, 1, 0));
        tbl.push_back(v(0, 0,  1, 0,  0, 0,  0,   0,  0, 0, 0, 0, 1, 0));
        tbl.push_back(v(0, 0,  0, 0,  0, 0,  0,   0,  0, 0, 0, 0, 1, 0));

        // Reset state, checked while reset is still held.
        RST_N = 1'b0;
        drive(q);
        model_reset();
        #3;
        chk_out("reset", model_out(q));
        chk("reset.IssueOk_const", 64'(IssueOk), 64'd1);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;

        for (int i = 0; i < tbl.size(); i++) step(tbl[i].s, 1'b1, tbl[i].e, $sformatf("vec%0d", i));

        for (int i = 0; i < 400; i++) step(rand_stim(), 1'b0, none, $sformatf("rnd%0d", i));

        // Mid-run reset: x1 written and x2 busy, then reset without a clock edge.
        q = '{ra: 5'd0, rb: 5'd0, rd: 5'd0, rw: 5'd0, issue: 1'b0, we: 1'b0, flush: 1'b1,
              din: '0};
        step(q, 1'b0, none, "pre_flush");
        q = '{ra: 5'd0, rb: 5'd0, rd: 5'd2, rw: 5'd1, issue: 1'b1, we: 1'b1, flush: 1'b0,
              din: 64'h1234};
        step(q, 1'b0, none, "pre_load");
        q = '{ra: 5'd1, rb: 5'd2, rd: 5'd2, rw: 5'd0, issue: 1'b0, we: 1'b0, flush: 1'b0,
              din: '0};
        drive(q);
        #2;
        chk("midrst_before.Da", Da, 64'h1234);
        chk("midrst_before.IssueOk", 64'(IssueOk), 64'd0);
        chk("midrst_before.BusyCount", 64'(BusyCount), 64'd1);
        RST_N = 1'b0;
        #1;
        chk("midrst.Da", Da, 64'd0);
        chk("midrst.Db", Db, 64'd0);
        chk("midrst.BusyB", 64'(BusyB), 64'd0);
        chk("midrst.IssueOk", 64'(IssueOk), 64'd1);
        chk("midrst.BusyCount", 64'(BusyCount), 64'd0);
        model_reset();
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;

        for (int i = 0; i < 100; i++) step(rand_stim(), 1'b0, none, $sformatf("post%0d", i));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
